// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: two-channel round-robin arbiter feeding a one-beat output register with source select
module rr_sel_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    output logic              y_valid_o,
    output logic [DATA_W-1:0] y_data_o,
    output logic              y_sel_o,
    input  logic              y_ready_i
);
    logic              y_valid_q, y_valid_d;
    logic [DATA_W-1:0] y_data_q, y_data_d;
    logic              y_sel_q, y_sel_d;
    logic              last_q, last_d;
    logic              can_accept, gnt_a, gnt_b, a_xfer, b_xfer;

    // Grant the lone requester, or the one opposite the last winner on contention; gate readies by reset
    always_comb begin
        can_accept = !y_valid_q || y_ready_i;
        gnt_a      = a_valid_i && (!b_valid_i || last_q);
        gnt_b      = b_valid_i && (!a_valid_i || !last_q);
        a_ready_o  = !reset && can_accept && gnt_a;
        b_ready_o  = !reset && can_accept && gnt_b;
        a_xfer     = a_valid_i && a_ready_o;
        b_xfer     = b_valid_i && b_ready_o;
    end

    // Load the transferred beat, drain when taken downstream, otherwise hold
    always_comb begin
        y_valid_d = a_xfer || b_xfer || (y_valid_q && !y_ready_i);
        y_data_d  = a_xfer ? a_data_i : b_xfer ? b_data_i : y_data_q;
        y_sel_d   = a_xfer ? 1'b0 : b_xfer ? 1'b1 : y_sel_q;
        last_d    = a_xfer ? 1'b0 : b_xfer ? 1'b1 : last_q;
    end

    // State registers; last_q resets to B so A wins the first contention
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            y_sel_q   <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
            y_sel_q   <= y_sel_d;
            last_q    <= last_d;
        end
    end

    assign y_valid_o = y_valid_q;
    assign y_data_o  = y_data_q;
    assign y_sel_o   = y_sel_q;
endmodule
